// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared defaults, channel config struct and reset high-time helper for the clock divider
package clock_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 1;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } ch_cfg_t;

    // Reset high time: half the reset period rounded down, never below one cycle.
    function automatic int def_high(input int div);
        int h;
        h = (div + 1) / 2;
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/clock_channel.sv
// rtl/clock_channel.sv - one divided-clock channel with shadow/active config, counter, clk_out and tick registers
module clock_channel
    import clock_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(def_high(DEF_DIV));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_a;
    logic [CNT_W-1:0] high_a;
    logic [CNT_W-1:0] div_s;
    logic [CNT_W-1:0] high_s;

    logic [CNT_W-1:0] div_s_nxt;
    logic [CNT_W-1:0] high_s_nxt;
    logic [CNT_W-1:0] div_eff;
    logic             wrap;
    logic             out_nxt;

    // A write landing in the same cycle as an idle copy or a wrap is forwarded
    // straight into the active registers, so it governs the very next period.
    always_comb begin
        div_s_nxt  = wr ? wr_div  : div_s;
        high_s_nxt = wr ? wr_high : high_s;
        div_eff    = (div_a == '0) ? CNT_W'(1) : div_a;
        wrap       = (cnt >= div_eff);
        out_nxt    = run && (cnt < high_a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_a   <= RST_DIV;
            high_a  <= RST_HIGH;
            div_s   <= RST_DIV;
            high_s  <= RST_HIGH;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            div_s   <= div_s_nxt;
            high_s  <= high_s_nxt;
            clk_out <= out_nxt;
            tick    <= out_nxt && !clk_out;
            if (!run || wrap) begin
                cnt    <= '0;
                div_a  <= div_s_nxt;
                high_a <= high_s_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - multi-channel programmable clock divider with per-channel shadow configuration
module clock_divider
    import clock_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_div,
    input  logic [CNT_W-1:0]  load_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] wr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = load && (load_ch == CH_W'(i));

        clock_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (en && ch_en[i]),
            .wr      (wr[i]),
            .wr_div  (load_div),
            .wr_high (load_high),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - self-checking bench for clock_divider: vector table, corner sequences, random vs model
module tb_clock_divider;
    import clock_pkg::*;

    localparam int NCH = 4;
    localparam int DEFD = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ch_en;
    logic       load;
    logic [1:0] load_ch;
    logic [7:0] load_div;
    logic [7:0] load_high;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    clock_divider #(.NUM_CH(NCH), .CNT_W(8), .DEF_DIV(DEFD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_en     (ch_en),
        .load      (load),
        .load_ch   (load_ch),
        .load_div  (load_div),
        .load_high (load_high),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Reference: each channel knows its position inside the current period and the
    // period/high figures fixed when that period began.
    int m_sdiv[NCH], m_shigh[NCH], m_pdiv[NCH], m_phigh[NCH], m_pos[NCH];
    logic [3:0] m_out, m_tick;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        int h;
        h = (DEFD + 1) / 2;
        if (h < 1) h = 1;
        for (int c = 0; c < NCH; c++) begin
            m_sdiv[c] = DEFD; m_shigh[c] = h;
            m_pdiv[c] = DEFD; m_phigh[c] = h;
            m_pos[c]  = 0;
        end
        m_out = '0; m_tick = '0;
    endtask

    task automatic model_edge();
        logic [3:0] nout;
        int period;
        for (int c = 0; c < NCH; c++) begin
            if (load && load_ch == 2'(c)) begin
                m_sdiv[c] = load_div; m_shigh[c] = load_high;
            end
            period = ((m_pdiv[c] == 0) ? 1 : m_pdiv[c]) + 1;
            if (en && ch_en[c]) begin
                nout[c] = (m_pos[c] < m_phigh[c]);
                m_pos[c] = m_pos[c] + 1;
                if (m_pos[c] == period) m_pos[c] = 0;
            end else begin
                nout[c] = 1'b0;
                m_pos[c] = 0;
            end
            if (m_pos[c] == 0) begin
                m_pdiv[c] = m_sdiv[c]; m_phigh[c] = m_shigh[c];
            end
        end
        m_tick = nout & ~m_out;
        m_out  = nout;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check("model_clk_out", int'(clk_out), int'(m_out));
        check("model_tick", int'(tick), int'(m_tick));
        load = 1'b0;
    endtask

    task automatic do_load(input int ch, input int dv, input int hi);
        load = 1'b1; load_ch = 2'(ch); load_div = 8'(dv); load_high = 8'(hi);
    endtask

    typedef struct {
        logic       en;
        logic [3:0] ch_en;
        logic       load;
        logic [1:0] load_ch;
        ch_cfg_t    cfg;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
    } vec_t;

    vec_t vt[12];
    int   t2[$];
    int   hi_cnt, tk_cnt;

    initial begin
        vt[0]  = '{1'b1, 4'hF, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'hF, 4'hF};
        vt[1]  = '{1'b1, 4'hF, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h0, 4'h0};
        vt[2]  = '{1'b1, 4'hF, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'hF, 4'hF};
        vt[3]  = '{1'b0, 4'hF, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h0, 4'h0};
        vt[4]  = '{1'b1, 4'h1, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h1, 4'h1};
        vt[5]  = '{1'b1, 4'h1, 1'b1, 2'd1, '{div:8'd4, high:8'd2}, 4'h0, 4'h0};
        vt[6]  = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h3, 4'h3};
        vt[7]  = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h2, 4'h0};
        vt[8]  = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h1, 4'h1};
        vt[9]  = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h0, 4'h0};
        vt[10] = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h1, 4'h1};
        vt[11] = '{1'b1, 4'h3, 1'b0, 2'd0, '{div:8'd0, high:8'd0}, 4'h2, 4'h2};

        rst = 1'b1; en = 1'b0; ch_en = '0; load = 1'b0; load_ch = '0; load_div = '0; load_high = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick", int'(tick), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            en = vt[i].en; ch_en = vt[i].ch_en; load = vt[i].load; load_ch = vt[i].load_ch;
            load_div = vt[i].cfg.div; load_high = vt[i].cfg.high;
            step();
            check($sformatf("tbl%0d_clk_out", i), int'(clk_out), int'(vt[i].exp_clk));
            check($sformatf("tbl%0d_tick", i), int'(tick), int'(vt[i].exp_tick));
        end

        // ch2: div 3 / high 2, then a mid-period reload to div 9 / high 5
        do_load(2, 3, 2);
        step();
        ch_en = 4'h7;
        t2.delete(); hi_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 5) do_load(2, 9, 5);
            step();
            if (tick[2]) t2.push_back(k);
            if (k >= 8 && k < 18 && clk_out[2]) hi_cnt++;
        end
        check("ch2_tick_count", t2.size(), 5);
        if (t2.size() >= 4) begin
            check("ch2_old_period_a", t2[1] - t2[0], 4);
            check("ch2_old_period_b", t2[2] - t2[1], 4);
            check("ch2_new_period", t2[3] - t2[2], 10);
        end
        check("ch2_new_high", hi_cnt, 5);

        // ch3: high 0 holds low, then high > divide holds high with one tick
        ch_en = 4'hF;
        do_load(3, 3, 0);
        repeat (3) step();
        hi_cnt = 0; tk_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            hi_cnt += int'(clk_out[3]); tk_cnt += int'(tick[3]);
        end
        check("ch3_zero_high", hi_cnt, 0);
        check("ch3_zero_ticks", tk_cnt, 0);
        do_load(3, 3, 7);
        hi_cnt = 0; tk_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k >= 8) hi_cnt += int'(clk_out[3]);
            tk_cnt += int'(tick[3]);
        end
        check("ch3_hold_high", hi_cnt, 8);
        check("ch3_one_tick", tk_cnt, 1);

        // global enable dropped mid-period, then restored
        repeat (2) step();
        en = 1'b0;
        repeat (3) begin
            step();
            check("en_low_clk_out", int'(clk_out), 0);
        end
        en = 1'b1;
        step();
        check("restart_clk_out", int'(clk_out), 'hF);
        check("restart_tick", int'(tick), 'hF);

        // asynchronous reset away from a clock edge
        repeat (3) step();
        #2 rst = 1'b1;
        #1 check("async_rst_clk_out", int'(clk_out), 0);
        check("async_rst_tick", int'(tick), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_clk_a", int'(clk_out), 'hF);
        step();
        check("post_rst_clk_b", int'(clk_out), 'h0);
        step();
        check("post_rst_clk_c", int'(clk_out), 'hF);

        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) ch_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                do_load($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 8));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
